// File: rtl/rv_muldiv_if.sv
// rv_muldiv_if
// Request/response bundle between the issue logic, the iterative mul/div
// unit and the writeback path.
//
// Signals:
//   req_valid  issue -> unit   request valid
//   req_ready  unit  -> issue  unit can accept a request this cycle
//   funct3     issue -> unit   M-extension operation select
//   op1, op2   issue -> unit   rs1 / rs2 values (XLEN bits)
//   req_rd     issue -> unit   destination tag
//   rsp_valid  unit  -> wb     result valid
//   rsp_ready  wb    -> unit   consumer takes the result
//   result     unit  -> wb     result value (XLEN bits)
//   rsp_rd     unit  -> wb     destination tag of the result
//   busy       unit  -> issue  unit is not idle
//
// Modports: master (issue/writeback side), slave (the unit).

interface rv_muldiv_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      req_rd;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rsp_rd;
    logic            busy;

    modport master (
        output req_valid, funct3, op1, op2, req_rd, rsp_ready,
        input  req_ready, rsp_valid, result, rsp_rd, busy
    );

    modport slave (
        input  req_valid, funct3, op1, op2, req_rd, rsp_ready,
        output req_ready, rsp_valid, result, rsp_rd, busy
    );
endinterface

// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter
// Iterative RV32M/RV64M multiply/divide unit. One operation at a time is
// accepted over a valid/ready handshake; multiplies retire MUL_STEP
// multiplier bits per cycle (shift-add), divides retire DIV_STEP quotient
// bits per cycle (restoring). A final FIX cycle applies signs, selects the
// result half and applies the RISC-V divide special cases.
//
// Parameters:
//   XLEN      operand/result width, 32 or 64
//   MUL_STEP  multiplier bits per CALC cycle, 1/2/4 (must divide XLEN)
//   DIV_STEP  quotient bits per CALC cycle, 1 or 2
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst    asynchronous active-high reset
//   flush  synchronous abort, overrides every other input
//   bus    rv_muldiv_if.slave request/response bundle
//
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, divide-by-zero, signed overflow and
//                        multiply-by-zero skip CALC and finish one cycle
//                        after accept. Results are identical either way.

module rv_muldiv_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2,
    parameter int DIV_STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    rv_muldiv_if.slave   bus
);

    localparam int MUL_N = XLEN / MUL_STEP;
    localparam int DIV_N = XLEN / DIV_STEP;
    localparam int CW    = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_N - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(DIV_N - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]        op;
    logic [4:0]        tag;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     count;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   result;
    logic [4:0]        result_rd;

    logic              accept;
    logic              early;
    logic              in_div;
    logic              sign1;
    logic              sign2;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              in_div_zero;
    logic              in_overflow;
    logic [2*XLEN-1:0] acc_init;
    logic [CW-1:0]     last_count;

    logic [XLEN+MUL_STEP-1:0] mul_partial;
    logic [2*XLEN-1:0]        mul_next;
    logic [2*XLEN-1:0]        div_next;
    logic [XLEN-1:0]          fix_result;

    assign bus.req_ready = (state == IDLE) || ((state == DONE) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready && !flush;
    assign last_count    = op[2] ? DIV_LAST : MUL_LAST;

    assign bus.rsp_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result;
    assign bus.rsp_rd    = result_rd;

    // Request decode: operand signedness per funct3, magnitudes, special
    // cases and the initial accumulator image. Multiplies keep the
    // multiplier in the low half of acc; divides keep {remainder, dividend}.
    // With early-out, the accumulator is preloaded with the final unsigned
    // answer so FIX can finish the job one cycle after accept.
    always_comb begin
        in_div      = bus.funct3[2];
        sign1       = bus.op1[XLEN-1] &&
                      (bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
        sign2       = bus.op2[XLEN-1] &&
                      (bus.funct3 inside {3'b001, 3'b100, 3'b110});
        mag1        = sign1 ? -bus.op1 : bus.op1;
        mag2        = sign2 ? -bus.op2 : bus.op2;
        in_div_zero = in_div && (bus.op2 == '0);
        in_overflow = in_div && !bus.funct3[0] &&
                      (bus.op1 == MIN_INT) && (bus.op2 == '1);
        acc_init    = in_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
`ifdef MULDIV_EARLY_OUT_EN
        early = in_div ? (in_div_zero || in_overflow)
                       : ((bus.op1 == '0) || (bus.op2 == '0));
        if (in_div_zero) begin
            acc_init = {mag1, {XLEN{1'b1}}};
        end else if (!in_div && early) begin
            acc_init = '0;
        end
`else
        early = 1'b0;
`endif
    end

    // One multiply step: add multiplicand times the next MUL_STEP multiplier
    // bits into the upper half, then shift the whole accumulator right so the
    // consumed multiplier bits fall off and product bits move in.
    always_comb begin
        mul_partial = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]};
        for (int k = 0; k < MUL_STEP; k++) begin
            if (acc[k]) begin
                mul_partial = mul_partial + ({{MUL_STEP{1'b0}}, mcand} << k);
            end
        end
        mul_next = {mul_partial, acc[XLEN-1:MUL_STEP]};
    end

    // DIV_STEP restoring-division steps. The dividend shifts out of the top
    // of the low half into the remainder while quotient bits shift in at the
    // bottom. The remainder stays below the divisor, so XLEN+1 bits are
    // enough for the trial subtraction. A zero divisor naturally yields an
    // all-ones quotient with the dividend left in the remainder.
    always_comb begin
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] q;
        logic [XLEN:0]   shifted;
        logic [XLEN:0]   diff;
        r       = acc[2*XLEN-1:XLEN];
        q       = acc[XLEN-1:0];
        shifted = '0;
        diff    = '0;
        for (int k = 0; k < DIV_STEP; k++) begin
            shifted = {r, q[XLEN-1]};
            diff    = shifted - {1'b0, mcand};
            q       = {q[XLEN-2:0], ~diff[XLEN]};
            r       = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        end
        div_next = {r, q};
    end

    // Sign correction and result selection. The quotient is negated when the
    // operand signs differ, the remainder follows the dividend sign; the two
    // RISC-V divide special cases then override the quotient/remainder.
    always_comb begin
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg_res ? -acc : acc;
        quo  = acc[XLEN-1:0];
        rem  = acc[2*XLEN-1:XLEN];
        if (neg_res) begin
            quo = -quo;
        end
        if (neg_rem) begin
            rem = -rem;
        end
        if (div_zero) begin
            quo = '1;
        end
        if (overflow) begin
            quo = MIN_INT;
            rem = '0;
        end
        if (op[2]) begin
            fix_result = op[1] ? rem : quo;
        end else begin
            fix_result = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE can hand off and accept on the same edge, so a
    // new request goes straight to CALC (or FIX for an early-out case).
    // Flush wins over everything.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = early ? FIX : CALC;
                end
            end
            CALC: begin
                if (count == last_count) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_next = early ? FIX : CALC;
                end else if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Datapath: latch the request on accept, iterate in CALC, and register
    // the corrected result in FIX so the outputs stay stable through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op        <= '0;
            tag       <= '0;
            mcand     <= '0;
            acc       <= '0;
            count     <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            result    <= '0;
            result_rd <= '0;
        end else if (flush) begin
            count     <= '0;
            result    <= '0;
            result_rd <= '0;
        end else begin
            if (accept) begin
                op       <= bus.funct3;
                tag      <= bus.req_rd;
                mcand    <= in_div ? mag2 : mag1;
                acc      <= acc_init;
                count    <= '0;
                neg_res  <= sign1 ^ sign2;
                neg_rem  <= sign1;
                div_zero <= in_div_zero;
                overflow <= in_overflow;
            end else if (state == CALC) begin
                acc   <= op[2] ? div_next : mul_next;
                count <= count + CW'(1);
            end
            if (state == FIX) begin
                result    <= fix_result;
                result_rd <= tag;
            end
        end
    end

endmodule

// File: tb/tb_rv_muldiv_iter.sv
// tb_rv_muldiv_iter
// Directed, table-driven bench for rv_muldiv_iter (XLEN=32, MUL_STEP=2,
// DIV_STEP=1) with hand-written sequences for back-pressure, flush and
// asynchronous reset. Expected latencies follow MULDIV_EARLY_OUT_EN.

module tb_rv_muldiv_iter;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 17;
    localparam int DIV_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] expect_val;
        bit          special;
    } vec_t;

    localparam int NV = 23;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   compared   = 0;
    int   mismatched = 0;
    vec_t vecs[NV];

    rv_muldiv_if #(.XLEN(XLEN)) bus ();

    rv_muldiv_iter #(
        .XLEN(XLEN),
        .MUL_STEP(2),
        .DIV_STEP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        bus.funct3    = f3;
        bus.op1       = a;
        bus.op2       = b;
        bus.req_rd    = rd;
        bus.req_valid = 1'b1;
        #1 check_output("ready at issue", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.rsp_valid && lat < 200);
    endtask

    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd,
                                  output int lat);
        issue(f3, a, b, rd);
        wait_result(lat);
    endtask

    task automatic hand_off();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check_output("valid after handoff", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int exp_lat;
        bit seen;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 1'b0};
        vecs[4]  = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 5'd5,  32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{3'b000, 32'h0001_0000, 32'h0001_0000, 5'd6,  32'h0000_0000, 1'b0};
        vecs[6]  = '{3'b011, 32'h0001_0000, 32'h0001_0000, 5'd7,  32'h0000_0001, 1'b0};
        vecs[7]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{3'b101, 32'd100,       32'd7,         5'd10, 32'd14,        1'b0};
        vecs[10] = '{3'b111, 32'd100,       32'd7,         5'd11, 32'd2,         1'b0};
        vecs[11] = '{3'b100, 32'hFFFF_FF9C, 32'd7,         5'd12, 32'hFFFF_FFF2, 1'b0};
        vecs[12] = '{3'b110, 32'd100,       32'hFFFF_FFF9, 5'd13, 32'd2,         1'b0};
        vecs[13] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1'b0};
        vecs[14] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0};
        vecs[15] = '{3'b100, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1'b1};
        vecs[16] = '{3'b110, 32'd5,         32'd0,         5'd17, 32'd5,         1'b1};
        vecs[17] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1'b1};
        vecs[18] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 1'b1};
        vecs[19] = '{3'b111, 32'hFFFF_FFF9, 32'd0,         5'd20, 32'hFFFF_FFF9, 1'b1};
        vecs[20] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         5'd21, 32'hFFFF_FFF9, 1'b1};
        vecs[21] = '{3'b000, 32'h0000_3039, 32'd0,         5'd22, 32'h0000_0000, 1'b1};
        vecs[22] = '{3'b001, 32'd0,         32'hFFFF_FFFF, 5'd23, 32'h0000_0000, 1'b1};

        rst           = 1'b1;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.funct3    = 3'b000;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.req_rd    = '0;

        #12;
        check_output("reset valid",  32'(bus.rsp_valid), 32'd0);
        check_output("reset busy",   32'(bus.busy),      32'd0);
        check_output("reset result", bus.result,         32'd0);
        check_output("reset rd",     {27'b0, bus.rsp_rd}, 32'd0);
        check_output("reset ready",  32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] running %0d table vectors", NV);
        for (int i = 0; i < NV; i++) begin
            exp_lat = vecs[i].f3[2] ? DIV_LAT : MUL_LAT;
            if (EARLY && vecs[i].special) begin
                exp_lat = 1;
            end
            apply_stimulus(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, lat);
            check_output($sformatf("v%0d result", i), bus.result, vecs[i].expect_val);
            check_output($sformatf("v%0d rd", i), {27'b0, bus.rsp_rd}, {27'b0, vecs[i].rd});
            check_output($sformatf("v%0d latency", i), 32'(lat), 32'(exp_lat));
            hand_off();
        end

        $display("[TB] back-pressure in DONE");
        apply_stimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, lat);
        check_output("stall first latency", 32'(lat), 32'(MUL_LAT));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_output("stall valid",  32'(bus.rsp_valid), 32'd1);
            check_output("stall result", bus.result,         32'hFFFF_FFEB);
            check_output("stall rd",     {27'b0, bus.rsp_rd}, 32'd9);
            check_output("stall ready",  32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.funct3    = 3'b011;
        bus.op1       = 32'hFFFF_FFFF;
        bus.op2       = 32'hFFFF_FFFF;
        bus.req_rd    = 5'd4;
        bus.req_valid = 1'b1;
        #1 check_output("b2b ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check_output("b2b valid drop", 32'(bus.rsp_valid), 32'd0);
        check_output("b2b busy",       32'(bus.busy),      32'd1);
        wait_result(lat);
        check_output("b2b latency", 32'(lat), 32'(MUL_LAT));
        check_output("b2b result",  bus.result, 32'hFFFF_FFFE);
        check_output("b2b rd",      {27'b0, bus.rsp_rd}, 32'd4);
        hand_off();

        $display("[TB] flush mid-CALC");
        issue(3'b101, 32'd100, 32'd7, 5'd11);
        repeat (10) @(posedge clk);
        #1;
        check_output("flush pre busy", 32'(bus.busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_output("flush busy",   32'(bus.busy),      32'd0);
        check_output("flush valid",  32'(bus.rsp_valid), 32'd0);
        check_output("flush result", bus.result,         32'd0);
        check_output("flush rd",     {27'b0, bus.rsp_rd}, 32'd0);
        @(negedge clk);
        bus.funct3    = 3'b000;
        bus.op1       = 32'd3;
        bus.op2       = 32'd5;
        bus.req_rd    = 5'd3;
        bus.req_valid = 1'b1;
        flush         = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        check_output("flush blocks accept", 32'(bus.busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid || bus.busy) begin
                seen = 1'b1;
            end
        end
        check_output("flush no result", 32'(seen), 32'd0);

        $display("[TB] asynchronous reset mid-CALC");
        apply_stimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, lat);
        hand_off();
        check_output("held result", bus.result, 32'hFFFF_FFEB);
        issue(3'b000, 32'd3, 32'd5, 5'd2);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_output("areset valid",  32'(bus.rsp_valid), 32'd0);
        check_output("areset result", bus.result,         32'd0);
        check_output("areset rd",     {27'b0, bus.rsp_rd}, 32'd0);
        check_output("areset busy",   32'(bus.busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_output("post reset ready", 32'(bus.req_ready), 32'd1);

        apply_stimulus(3'b101, 32'd100, 32'd7, 5'd10, lat);
        check_output("recover result",  bus.result, 32'd14);
        check_output("recover latency", 32'(lat), 32'(DIV_LAT));
        hand_off();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rv_muldiv_iter.md
# rv_muldiv_iter

Parametrised iterative RV32M/RV64M multiply/divide unit with a valid/ready handshake on both sides, replacing the fixed 1-bit-per-cycle mul/div sequencing embedded in the execute stage. Sits beside the execute-stage ALU: the issue logic hands it one M-extension operation at a time, and the writeback path consumes its result. Supports a configurable multiply radix, back-to-back issue, pipeline flush, and the RISC-V special-case results.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- MUL_STEP, 2: multiplier bits retired per CALC cycle; 1, 2 or 4; must divide XLEN.
- DIV_STEP, 1: quotient bits per CALC cycle; 1 or 2.
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous abort; has priority over every other input.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request this cycle.
- i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_op1, i_op2  in  XLEN  rs1, rs2 values.
- i_rd  in  5  destination tag, returned unchanged.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer takes the result.
- o_result  out  XLEN  result.
- o_rd  out  5  tag of the result.
- o_busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset/flush → IDLE, o_valid=0, o_result=0, o_rd=0, counter=0.
- Accept = i_valid & o_ready & !i_flush. o_ready = (state==IDLE) | (state==DONE & i_ready).
- On accept: latch funct3, rd, operand magnitudes and sign flags (signed per funct3: MULH both; MULHSU op1 only; DIV/REM both), counter=0, → CALC.
- CALC, multiply: shift-add of |op1| by MUL_STEP bits of |op2| per cycle into a 2·XLEN accumulator; N = XLEN/MUL_STEP cycles.
- CALC, divide: restoring division of |op1| by |op2|, DIV_STEP quotient bits per cycle; N = XLEN/DIV_STEP cycles.
- Counter increments each CALC cycle; at counter == N-1 → FIX.
- FIX: negate product if signs differ; select low half (MUL) or high half (MULH*); quotient negated if signs differ, remainder takes dividend sign. Special cases override: divisor 0 → quotient all ones, remainder = op1; signed op1 = −2^(XLEN−1), op2 = −1 → quotient = op1, remainder 0. → DONE, o_valid=1.
- DONE: o_valid held with stable o_result/o_rd until i_ready; then → IDLE, or directly → CALC if a new request is accepted in the same cycle.
- Flush in any state: → IDLE next edge, result dropped; a request presented with i_flush is not accepted.
- Reset mid-operation: immediate return to IDLE, all outputs 0.

## Timing
- Accept at edge t: o_valid high after edge t+N+1 (latency N+1 cycles), N as above.
- XLEN=32: MUL_STEP=2 → 17 cycles; DIV_STEP=1 → 33 cycles.
- Back-to-back: result handed off and next request accepted on the same edge; no bubble.
- Outputs registered; o_ready combinational only from state and i_ready.

## Configuration
- MULDIV_EARLY_OUT_EN defined: at accept, divisor 0, signed overflow, or either multiply operand 0 skip CALC/FIX; result computed from the special-case rules, DONE after edge t+1 (latency 1).
- Undefined: every operation takes the full N+1 cycles; FIX still applies the special-case overrides, results identical.

## Test plan
- XLEN=32, MUL_STEP=2: MUL 7 × −3 → 0xFFFFFFEB, o_valid exactly 17 cycles after accept; MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same → 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2; 33-cycle latency.
- DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5; DIV 0x80000000 / −1 → 0x80000000, REM → 0; with MULDIV_EARLY_OUT_EN latency 1, without latency 33.
- Hold i_ready=0 for 5 cycles in DONE: o_valid, o_result, o_rd stable, o_ready=0; then i_ready=1 with i_valid=1 → new op accepted same edge, next result after N+1 cycles.
- Assert i_flush at CALC counter=10 → o_valid never asserts for that op, IDLE next cycle; i_valid with i_flush not accepted.
- Assert i_reset mid-CALC asynchronously → o_valid, o_result, o_rd, o_busy 0 before next clock edge.
